wb_write_queue: RTL and testbench
=================================

// Module: wb_write_queue
// PURPOSE
//  Write-back buffer directly upstream of the 32x32 register bank. Accepts
//  write requests (dest reg + data) from execute, queues them in order, and
//  drives the bank's write port (write/dr/wrData) one entry per cycle.
//  Forwards queued data to the bank's read addresses (sr1/sr2), so readers
//  see values still waiting in the queue.
// PARAMETERS
//  DEPTH   4   queue entries; power of 2, >=2
//  AW      5   register address width (32 registers)
//  DW      32  data width
// PORTS
//  clk       in   1              clock; all state updates on posedge
//  reset     in   1              synchronous, active-high
//  in_valid  in   1              upstream write request present
//  in_ready  out  1              queue can accept (= !full)
//  in_dr     in   AW             destination register of request
//  in_data   in   DW             data of request
//  drain_en  in   1              permit draining the head to the bank this cycle
//  write     out  1              bank write enable
//  dr        out  AW             bank write address (head entry)
//  wrData    out  DW             bank write data (head entry)
//  sr1, sr2  in   AW             bank read addresses, snooped for forwarding
//  hit1,hit2 out  1              queue holds a pending write to sr1 / sr2
//  fwd1,fwd2 out  DW             data of the youngest pending write to sr1 / sr2
//  count     out  $clog2(DEPTH)+1  number of occupied entries
//  full      out  1              count == DEPTH
//  empty     out  1              count == 0
// BEHAVIOUR
//  - Storage: circular buffer, rd_ptr/wr_ptr wrap modulo DEPTH; count tracked explicitly.
//  - Push: in_valid && in_ready at posedge -> entry written at wr_ptr, wr_ptr++, count++.
//  - in_ready = !full. No push when full, even with a same-cycle pop.
//    Data offered while full is not taken; upstream holds it.
//  - Pop: write = !empty && drain_en (combinational). dr/wrData = head entry whenever !empty.
//    When write=1 at posedge, the bank captures the head and rd_ptr++, count--.
//  - Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
//  - Latency: request pushed at edge N into an empty queue -> write=1 during cycle
//    after N -> in the bank at edge N+1 (if drain_en=1). Strict FIFO order.
//  - Forwarding: purely combinational from registered queue contents.
//    hitX=1 if any occupied entry has dr==srX. fwdX = data of the youngest such entry
//    (the one closest to wr_ptr). fwdX = 0 when hitX=0.
//    The same-cycle in_* request is NOT forwarded.
//    The head being written this cycle still counts as a hit.
//  - Register 0 has no special treatment.
//  - Reset (sync, any time, incl. mid-drain): pointers=0, count=0, empty=1, full=0,
//    in_ready=1, write=0, hit1=hit2=0, fwd1=fwd2=0.
//    dr/wrData are don't-care while empty; drive 0. Entry contents need no reset.
//    Reset takes priority over same-edge push/pop; those are dropped.
//  - Outputs stay stable under empty/idle; no X on any output after the first reset edge.
// TESTING
//  1 drain_en=0; push (dr,data)=(k,10*k) for k=1..4 -> count=4, full=1, in_ready=0;
//    5th request held, count stays 4.
//  2 From 1, drain_en=1, no pushes -> write=1 for 4 cycles; dr=1,2,3,4 with wrData=10,20,30,40;
//    then empty=1, write=0. Bank reads reg[3]=30.
//  3 drain_en=0; push (7,70),(7,77); sr1=7, sr2=8 -> hit1=1, fwd1=77, hit2=0, fwd2=0.
//    Drain 1 entry -> fwd1 still 77; drain 2nd -> hit1=0.
//  4 drain_en=1, continuous in_valid with dr=k, data=10*k for k=0..31 ->
//    count<=1 throughout, pointers wrap 8x.
//    Bank readback of all 32 regs gives reg[k]=10*k.
//  5 Queue holds 3 entries; assert reset one cycle while in_valid=1 and drain_en=1 ->
//    next cycle count=0, write=0, hit*=0. The dropped entries never reach the bank.
//  6 count=2, in_valid=1, drain_en=1 for 3 cycles -> count stays 2; write order = push order.

Source files
------------

// File: rtl/wb_write_queue.sv
// In-order write-back queue ahead of the register bank. It drains one entry per
// cycle into the bank write port and forwards pending data to the bank readers.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_dr,
    input  logic [DW-1:0]            in_data,
    input  logic                     drain_en,
    output logic                     write,
    output logic [AW-1:0]            dr,
    output logic [DW-1:0]            wrData,
    input  logic [AW-1:0]            sr1,
    input  logic [AW-1:0]            sr2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DW-1:0]            fwd1,
    output logic [DW-1:0]            fwd2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] mem_dr   [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] idx;
    logic          push;
    logic          pop;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign in_ready = !full;

    // Handshake: a request transfers on a posedge where in_valid && in_ready;
    // the upstream holds in_dr/in_data stable until then. Reset drops both sides.
    assign push  = in_valid && in_ready && !reset;
    assign pop   = !empty && drain_en && !reset;
    assign write = pop;

    assign dr     = empty ? '0 : mem_dr[rd_ptr];
    assign wrData = empty ? '0 : mem_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dr[wr_ptr]   <= in_dr;
            mem_data[wr_ptr] <= in_data;
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (mem_dr[idx] == sr1) begin
                    hit1 = 1'b1;
                    fwd1 = mem_data[idx];
                end
                if (mem_dr[idx] == sr2) begin
                    hit2 = 1'b1;
                    fwd2 = mem_data[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_dr = '0;
    logic [DW-1:0] in_data = '0;
    logic          drain_en = 1'b0;
    logic          write;
    logic [AW-1:0] dr;
    logic [DW-1:0] wrData;
    logic [AW-1:0] sr1 = '0;
    logic [AW-1:0] sr2 = '0;
    logic          hit1, hit2;
    logic [DW-1:0] fwd1, fwd2;
    logic [2:0]    count;
    logic          full, empty;

    int checks = 0;
    int failures = 0;

    // Reference model: queue of {dr,data}, front = oldest.
    logic [AW+DW-1:0] exp_q[$];
    logic             model_live = 1'b0;
    logic [DW-1:0]    bank_cap [32];

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_dr(in_dr), .in_data(in_data), .drain_en(drain_en), .write(write),
        .dr(dr), .wrData(wrData), .sr1(sr1), .sr2(sr2), .hit1(hit1), .hit2(hit2),
        .fwd1(fwd1), .fwd2(fwd2), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at the active edge: reset wins, otherwise pop head and/or append.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_live = 1'b1;
        end else if (model_live) begin
            logic do_pop, do_push;
            do_pop  = (exp_q.size() != 0) && drain_en;
            do_push = in_valid && (exp_q.size() < DEPTH);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({in_dr, in_data});
        end
    end

    // Compare process: outputs sampled mid-low-phase against the model.
    always @(negedge clk) begin
        #2;
        if (model_live) begin
            logic          e_hit1, e_hit2, e_write;
            logic [DW-1:0] e_fwd1, e_fwd2, e_data;
            logic [AW-1:0] e_dr;
            int            n;
            n = exp_q.size();
            e_hit1 = 1'b0; e_hit2 = 1'b0; e_fwd1 = '0; e_fwd2 = '0;
            for (int i = n - 1; i >= 0; i--) begin
                if (!e_hit1 && exp_q[i][AW+DW-1:DW] == sr1) begin
                    e_hit1 = 1'b1; e_fwd1 = exp_q[i][DW-1:0];
                end
                if (!e_hit2 && exp_q[i][AW+DW-1:DW] == sr2) begin
                    e_hit2 = 1'b1; e_fwd2 = exp_q[i][DW-1:0];
                end
            end
            e_dr    = (n != 0) ? exp_q[0][AW+DW-1:DW] : '0;
            e_data  = (n != 0) ? exp_q[0][DW-1:0] : '0;
            e_write = (n != 0) && drain_en && !reset;
            check("count", 64'(count), 64'(n));
            check("full", 64'(full), 64'(n == DEPTH));
            check("empty", 64'(empty), 64'(n == 0));
            check("in_ready", 64'(in_ready), 64'(n != DEPTH));
            check("write", 64'(write), 64'(e_write));
            check("dr", 64'(dr), 64'(e_dr));
            check("wrData", 64'(wrData), 64'(e_data));
            check("hit1", 64'(hit1), 64'(e_hit1));
            check("fwd1", 64'(fwd1), 64'(e_fwd1));
            check("hit2", 64'(hit2), 64'(e_hit2));
            check("fwd2", 64'(fwd2), 64'(e_fwd2));
            // Behaves as the register bank: captures whatever the write port presents.
            if (write === 1'b1) bank_cap[dr] = wrData;
        end
    end

    task automatic drive(input logic rst, input logic v, input logic [AW-1:0] d,
                         input logic [DW-1:0] dat, input logic den,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        @(negedge clk);
        reset = rst; in_valid = v; in_dr = d; in_data = dat;
        drain_en = den; sr1 = s1; sr2 = s2;
        #3;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) bank_cap[r] = '0;

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rst_count", 64'(count), 0);
        check("rst_empty", 64'(empty), 1);
        check("rst_full", 64'(full), 0);
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_write", 64'(write), 0);
        check("rst_hits", 64'({hit1, hit2}), 0);

        // Fill to full with drain disabled; fifth request is held off.
        for (int k = 1; k <= 4; k++) drive(0, 1, AW'(k), DW'(10 * k), 0, 0, 0);
        drive(0, 1, 5, 50, 0, 0, 0);
        check("t1_count", 64'(count), 4);
        check("t1_full", 64'(full), 1);
        check("t1_in_ready", 64'(in_ready), 0);
        drive(0, 1, 5, 50, 0, 0, 0);
        check("t1_held_count", 64'(count), 4);

        // Drain in order.
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            check("t2_write", 64'(write), 1);
            check("t2_dr", 64'(dr), 64'(k));
            check("t2_wrData", 64'(wrData), 64'(10 * k));
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t2_empty", 64'(empty), 1);
        check("t2_write_off", 64'(write), 0);
        check("t2_bank3", 64'(bank_cap[3]), 30);

        // Forwarding of the youngest write to the same register.
        drive(0, 1, 7, 70, 0, 7, 8);
        drive(0, 1, 7, 77, 0, 7, 8);
        drive(0, 0, 0, 0, 1, 7, 8);
        check("t3_hit1", 64'(hit1), 1);
        check("t3_fwd1", 64'(fwd1), 77);
        check("t3_hit2", 64'(hit2), 0);
        check("t3_fwd2", 64'(fwd2), 0);
        drive(0, 0, 0, 0, 1, 7, 8);
        check("t3_fwd1_after1", 64'(fwd1), 77);
        check("t3_hit1_head", 64'(hit1), 1);
        drive(0, 0, 0, 0, 0, 7, 8);
        check("t3_hit1_gone", 64'(hit1), 0);
        check("t3_fwd1_gone", 64'(fwd1), 0);

        // Streaming through every register with drain on.
        for (int k = 0; k < 32; k++) begin
            drive(0, 1, AW'(k), DW'(10 * k), 1, 0, 0);
            check("t4_count_le1", 64'(count <= 1), 1);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 32; k++) check("t4_bank", 64'(bank_cap[k]), 64'(10 * k));

        // Reset mid-drain drops queued entries.
        for (int i = 0; i < 3; i++) drive(0, 1, AW'(20 + i), DW'(9990 + i), 0, 20, 21);
        drive(1, 1, 23, 9999, 1, 20, 21);
        drive(0, 0, 0, 0, 0, 20, 21);
        check("t5_count", 64'(count), 0);
        check("t5_write", 64'(write), 0);
        check("t5_hits", 64'({hit1, hit2}), 0);
        drive(0, 0, 0, 0, 1, 20, 21);
        check("t5_bank20", 64'(bank_cap[20]), 200);
        check("t5_bank22", 64'(bank_cap[22]), 220);

        // Steady push+pop at count 2.
        drive(0, 1, 1, 1001, 0, 0, 0);
        drive(0, 1, 2, 1002, 0, 0, 0);
        for (int k = 3; k <= 5; k++) begin
            drive(0, 1, AW'(k), DW'(1000 + k), 1, 0, 0);
            check("t6_count", 64'(count), 2);
            check("t6_dr", 64'(dr), 64'(k - 2));
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t6_count_end", 64'(count), 2);

        // Randomized traffic; small address range to provoke forwarding hits.
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
                  AW'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 1) == 1),
                  AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
        end
        drive(0, 0, 0, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
